// File: rtl/stq_commit_drain_if.sv
// D-cache store port between the store-queue drain engine and the cache.
// The drain side issues one request at a time; the cache answers with ack.
interface stq_commit_drain_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  dcStReq_o;
    logic [ADDR_WIDTH-1:0] dcStAddr_o;
    logic [DATA_WIDTH-1:0] dcStData_o;
    logic [1:0]            dcStSize_o;
    logic                  dcStAck_i;

    modport master (
        output dcStReq_o,
        output dcStAddr_o,
        output dcStData_o,
        output dcStSize_o,
        input  dcStAck_i
    );

    modport slave (
        input  dcStReq_o,
        input  dcStAddr_o,
        input  dcStData_o,
        input  dcStSize_o,
        output dcStAck_i
    );
endinterface

// File: rtl/stq_commit_drain.sv
// Store-queue commit/drain engine. Advances the commit pointer by the number
// of stores retiring each cycle, counts committed-but-unwritten stores and
// writes them to the D-cache one at a time, oldest first, freeing each
// store-queue entry as the cache accepts it.
module stq_commit_drain #(
    parameter int COMMIT_WIDTH = 4,
    parameter int SIZE_LSQ     = 32,
    parameter int SIZE_LSQ_LOG = 5,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [2:0]              commitStCount_i,
    output logic [SIZE_LSQ_LOG-1:0] stqCommitPtr_o,

    output logic [SIZE_LSQ_LOG-1:0] stqRdIndex_o,
    input  logic [ADDR_WIDTH-1:0]   stqRdAddr_i,
    input  logic [DATA_WIDTH-1:0]   stqRdData_i,
    input  logic [1:0]              stqRdSize_i,

    stq_commit_drain_if.master      dc,

    output logic                    stqDealloc_o,
    output logic [SIZE_LSQ_LOG-1:0] stqDeallocIndex_o,
    output logic [SIZE_LSQ_LOG-1:0] stqHeadPtr_o,
    output logic [SIZE_LSQ_LOG:0]   pendingCount_o,
    output logic                    drained_o
);

    localparam int PTR_W = SIZE_LSQ_LOG;
    localparam int CNT_W = SIZE_LSQ_LOG + 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0]        head_ptr_q, head_ptr_d;
    logic [CNT_W-1:0]        pending_q, pending_d;
    logic                    req_q, req_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [1:0]              size_q, size_d;
    logic                    dealloc_q, dealloc_d;
    logic [PTR_W-1:0]        dealloc_idx_q, dealloc_idx_d;
    logic                    ack_accepted;

    // An ack only counts while a request is actually outstanding.
    always_comb begin
        ack_accepted = req_q & dc.dcStAck_i;
        commit_ptr_d = commit_ptr_q + PTR_W'(commitStCount_i);
        pending_d    = pending_q + CNT_W'(commitStCount_i) - CNT_W'(ack_accepted);
    end

    // Drain FSM: IDLE launches the head entry when the registered count is
    // non-zero; REQ holds the payload until the cache accepts it.
    always_comb begin
        state_d       = state_q;
        head_ptr_d    = head_ptr_q;
        req_d         = req_q;
        addr_d        = addr_q;
        data_d        = data_q;
        size_d        = size_q;
        dealloc_d     = 1'b0;
        dealloc_idx_d = dealloc_idx_q;

        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    addr_d  = stqRdAddr_i;
                    data_d  = stqRdData_i;
                    size_d  = stqRdSize_i;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_accepted) begin
                    req_d         = 1'b0;
                    dealloc_d     = 1'b1;
                    dealloc_idx_d = head_ptr_q;
                    head_ptr_d    = head_ptr_q + PTR_W'(1);
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State registers; reset is asynchronous so the request drops at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            commit_ptr_q  <= '0;
            head_ptr_q    <= '0;
            pending_q     <= '0;
            req_q         <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            size_q        <= '0;
            dealloc_q     <= 1'b0;
            dealloc_idx_q <= '0;
        end else begin
            state_q       <= state_d;
            commit_ptr_q  <= commit_ptr_d;
            head_ptr_q    <= head_ptr_d;
            pending_q     <= pending_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            size_q        <= size_d;
            dealloc_q     <= dealloc_d;
            dealloc_idx_q <= dealloc_idx_d;
        end
    end

    // Overfilling the store queue or retiring too many stores is a bug upstream.
    always @(posedge clk) begin
        if (reset) begin
            assert ((int'(pending_q) + int'(commitStCount_i)) <= SIZE_LSQ);
            assert (int'(commitStCount_i) <= COMMIT_WIDTH);
        end
    end

    assign stqCommitPtr_o    = commit_ptr_q;
    assign stqHeadPtr_o      = head_ptr_q;
    assign stqRdIndex_o      = head_ptr_q;
    assign pendingCount_o    = pending_q;
    assign stqDealloc_o      = dealloc_q;
    assign stqDeallocIndex_o = dealloc_idx_q;
    assign drained_o         = (pending_q == '0) && (state_q == IDLE);

    assign dc.dcStReq_o  = req_q;
    assign dc.dcStAddr_o = addr_q;
    assign dc.dcStData_o = data_q;
    assign dc.dcStSize_o = size_q;

endmodule

// File: tb/tb_stq_commit_drain.sv
// Bench for stq_commit_drain: a store-queue memory model feeds the read port,
// a scoreboard of committed entries is compared against every accepted cache
// request and every dealloc pulse.
module tb_stq_commit_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  commit_cnt = 3'd0;
    logic [4:0]  commit_ptr, rd_index, dealloc_idx, head_ptr;
    logic [31:0] rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_size;
    logic        dealloc, drained;
    logic [5:0]  pending;

    stq_commit_drain_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dc_if ();

    stq_commit_drain dut (
        .clk               (clk),
        .reset             (rst_n),
        .commitStCount_i   (commit_cnt),
        .stqCommitPtr_o    (commit_ptr),
        .stqRdIndex_o      (rd_index),
        .stqRdAddr_i       (rd_addr),
        .stqRdData_i       (rd_data),
        .stqRdSize_i       (rd_size),
        .dc                (dc_if.master),
        .stqDealloc_o      (dealloc),
        .stqDeallocIndex_o (dealloc_idx),
        .stqHeadPtr_o      (head_ptr),
        .pendingCount_o    (pending),
        .drained_o         (drained)
    );

    always #5 clk = ~clk;

    // Store-queue contents model, read combinationally at the DUT's index.
    logic [31:0] mem_addr [32];
    logic [63:0] mem_data [32];
    logic [1:0]  mem_size [32];
    assign rd_addr = mem_addr[rd_index];
    assign rd_data = mem_data[rd_index];
    assign rd_size = mem_size[rd_index];

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
    } exp_t;

    exp_t       exp_q [$];
    logic [4:0] dq [$];
    int         errors = 0;
    int         checks = 0;
    logic [4:0] tb_cptr = 5'd0;
    logic [31:0] tb_seq = 32'd1;
    logic        mon_en = 1'b0;
    logic        acc_prev = 1'b0;

    // Write n fresh entries at the commit pointer, queue them as expected
    // stores and drive the retire count for the coming edge.
    task automatic push_entries(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx  = tb_cptr;
            e.addr = 32'h8000_0000 + (tb_seq << 3);
            e.data = {tb_seq, ~tb_seq};
            e.size = tb_seq[1:0];
            mem_addr[tb_cptr] = e.addr;
            mem_data[tb_cptr] = e.data;
            mem_size[tb_cptr] = e.size;
            exp_q.push_back(e);
            tb_cptr = tb_cptr + 5'd1;
            tb_seq  = tb_seq + 32'd1;
        end
        commit_cnt = 3'(n);
    endtask

    task automatic do_commit(input int n);
        push_entries(n);
        @(posedge clk); #1;
        commit_cnt = 3'd0;
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        commit_cnt = 3'd0;
        dc_if.dcStAck_i = 1'b0;
        exp_q.delete();
        dq.delete();
        tb_cptr = 5'd0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_drained(input int max_cycles, input string name);
        int n;
        n = 0;
        while (!drained && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (drained !== 1'b1) begin
            errors++;
            $display("FAIL %s: drained=%0b after %0d cycles, required 1", name, drained, n);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic [4:0] di;
        logic [4:0] diff;
        if (!mon_en) begin
            acc_prev = 1'b0;
        end else begin
            checks++;
            if (dealloc !== acc_prev) begin
                errors++;
                $display("FAIL dealloc_timing: stqDealloc=%0b, required %0b", dealloc, acc_prev);
            end
            if (dealloc === 1'b1) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL dealloc_unexpected: index=%0d, required no pulse", dealloc_idx);
                end else begin
                    di = dq.pop_front();
                    if (dealloc_idx !== di) begin
                        errors++;
                        $display("FAIL dealloc_index: got %0d, required %0d", dealloc_idx, di);
                    end
                end
            end
            acc_prev = dc_if.dcStReq_o & dc_if.dcStAck_i;
            if (acc_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL store_unexpected: addr=%0h, required no request", dc_if.dcStAddr_o);
                end else begin
                    e = exp_q.pop_front();
                    if (dc_if.dcStAddr_o !== e.addr || dc_if.dcStData_o !== e.data ||
                        dc_if.dcStSize_o !== e.size) begin
                        errors++;
                        $display("FAIL store_payload: got %0h/%0h/%0d, required %0h/%0h/%0d (entry %0d)",
                                 dc_if.dcStAddr_o, dc_if.dcStData_o, dc_if.dcStSize_o,
                                 e.addr, e.data, e.size, e.idx);
                    end
                    dq.push_back(e.idx);
                end
            end
            if (pending != 6'd32) begin
                diff = commit_ptr - head_ptr;
                checks++;
                if (diff !== pending[4:0]) begin
                    errors++;
                    $display("FAIL ptr_invariant: commit-head=%0d, pending=%0d", diff, pending);
                end
            end
        end
    end

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (dc_if.dcStReq_o !== 1'b0 || drained !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle: req=%0b drained=%0b, required 0/1", dc_if.dcStReq_o, drained);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (commit_ptr !== 5'd0 || head_ptr !== 5'd0 || pending !== 6'd0) begin
            errors++;
            $display("FAIL reset_ptrs: commit=%0d head=%0d pending=%0d, required 0/0/0",
                     commit_ptr, head_ptr, pending);
        end
        checks++;
        if (dealloc !== 1'b0 || dealloc_idx !== 5'd0 || dc_if.dcStAddr_o !== 32'd0 ||
            dc_if.dcStData_o !== 64'd0 || dc_if.dcStSize_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: dealloc=%0b idx=%0d addr=%0h data=%0h size=%0d, required all 0",
                     dealloc, dealloc_idx, dc_if.dcStAddr_o, dc_if.dcStData_o, dc_if.dcStSize_o);
        end
    endtask

    task automatic test_basic_drain();
        logic expv;
        apply_reset();
        dc_if.dcStAck_i = 1'b1;
        do_commit(3);
        for (int k = 1; k <= 7; k++) begin
            expv = (k == 2 || k == 4 || k == 6);
            checks++;
            if (dc_if.dcStReq_o !== expv) begin
                errors++;
                $display("FAIL basic_req_cycle%0d: req=%0b, required %0b", k, dc_if.dcStReq_o, expv);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (commit_ptr !== 5'd3 || head_ptr !== 5'd3 || drained !== 1'b1) begin
            errors++;
            $display("FAIL basic_final: commit=%0d head=%0d drained=%0b, required 3/3/1",
                     commit_ptr, head_ptr, drained);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ack_hold();
        logic [31:0] a0;
        logic [63:0] d0;
        logic [1:0]  s0;
        logic [5:0]  pexp;
        apply_reset();
        do_commit(1);
        @(posedge clk); #1;
        a0 = dc_if.dcStAddr_o;
        d0 = dc_if.dcStData_o;
        s0 = dc_if.dcStSize_o;
        for (int c = 0; c < 5; c++) begin
            pexp = (c == 0) ? 6'd1 : (c == 1) ? 6'd3 : 6'd5;
            checks++;
            if (dc_if.dcStReq_o !== 1'b1 || dc_if.dcStAddr_o !== a0 ||
                dc_if.dcStData_o !== d0 || dc_if.dcStSize_o !== s0) begin
                errors++;
                $display("FAIL hold_payload_c%0d: req=%0b addr=%0h, required 1/%0h", c,
                         dc_if.dcStReq_o, dc_if.dcStAddr_o, a0);
            end
            checks++;
            if (pending !== pexp) begin
                errors++;
                $display("FAIL hold_pending_c%0d: got %0d, required %0d", c, pending, pexp);
            end
            if (c == 0 || c == 1) push_entries(2);
            else commit_cnt = 3'd0;
            @(posedge clk); #1;
        end
        dc_if.dcStAck_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pending !== 6'd4 || head_ptr !== 5'd1 || dc_if.dcStReq_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_ack: pending=%0d head=%0d req=%0b, required 4/1/0",
                     pending, head_ptr, dc_if.dcStReq_o);
        end
        wait_drained(100, "hold_drain");
    endtask

    task automatic test_commit_and_ack();
        apply_reset();
        do_commit(2);
        @(posedge clk); #1;
        checks++;
        if (dc_if.dcStReq_o !== 1'b1 || pending !== 6'd2) begin
            errors++;
            $display("FAIL same_cycle_setup: req=%0b pending=%0d, required 1/2", dc_if.dcStReq_o, pending);
        end
        dc_if.dcStAck_i = 1'b1;
        do_commit(4);
        checks++;
        if (pending !== 6'd5) begin
            errors++;
            $display("FAIL same_cycle_pending: got %0d, required 5", pending);
        end
        wait_drained(100, "same_cycle_drain");
    endtask

    task automatic test_wrap();
        apply_reset();
        dc_if.dcStAck_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push_entries(4);
            @(posedge clk); #1;
        end
        do_commit(2);
        wait_drained(200, "wrap_prefill_drain");
        checks++;
        if (commit_ptr !== 5'd30 || head_ptr !== 5'd30) begin
            errors++;
            $display("FAIL wrap_start: commit=%0d head=%0d, required 30/30", commit_ptr, head_ptr);
        end
        do_commit(4);
        checks++;
        if (commit_ptr !== 5'd2) begin
            errors++;
            $display("FAIL wrap_commit_ptr: got %0d, required 2", commit_ptr);
        end
        wait_drained(100, "wrap_drain");
        checks++;
        if (head_ptr !== 5'd2 || pending !== 6'd0) begin
            errors++;
            $display("FAIL wrap_head: head=%0d pending=%0d, required 2/0", head_ptr, pending);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_handshake();
        apply_reset();
        dc_if.dcStAck_i = 1'b1;
        do_commit(2);
        @(posedge clk); #1;
        checks++;
        if (dc_if.dcStReq_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: req=%0b, required 1", dc_if.dcStReq_o);
        end
        #2;
        mon_en = 1'b0;
        exp_q.delete();
        dq.delete();
        tb_cptr = 5'd0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dc_if.dcStReq_o !== 1'b0 || pending !== 6'd0 || dealloc !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: req=%0b pending=%0d dealloc=%0b, required 0/0/0",
                     dc_if.dcStReq_o, pending, dealloc);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dealloc !== 1'b0 || dc_if.dcStReq_o !== 1'b0 || pending !== 6'd0 ||
                commit_ptr !== 5'd0 || head_ptr !== 5'd0) begin
                errors++;
                $display("FAIL midreset_release_%0d: dealloc=%0b req=%0b pending=%0d commit=%0d head=%0d",
                         k, dealloc, dc_if.dcStReq_o, pending, commit_ptr, head_ptr);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        dc_if.dcStAck_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem_addr[i] = 32'd0;
            mem_data[i] = 64'd0;
            mem_size[i] = 2'd0;
        end
        test_reset();
        test_basic_drain();
        test_ack_hold();
        test_commit_and_ack();
        test_wrap();
        test_reset_mid_handshake();
        checks++;
        if (exp_q.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d stores, %0d deallocs outstanding, required 0/0",
                     exp_q.size(), dq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
